// File: rtl/led_blink_array.sv
// N-channel LED blinker: per-channel off/on/blink/burst mode with four selectable half-periods.
// All channels restart together on a sync strobe or when the global enable returns.
module led_blink_array #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 25,
    parameter int unsigned HALF_0     = 25_000_000,
    parameter int unsigned HALF_1     = 250_000,
    parameter int unsigned HALF_2     = 500_000,
    parameter int unsigned HALF_3     = 2_500_000,
    parameter int unsigned BURST_LEN  = 3,
    parameter int unsigned GAP_HALVES = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  enable_i,
    input  logic                  sync_i,
    input  logic [2*NUM_CH-1:0]   mode_i,
    input  logic [2*NUM_CH-1:0]   rate_sel_i,
    output logic [NUM_CH-1:0]     led_o
);

    localparam int unsigned TogW = $clog2(2 * BURST_LEN + 1);
    localparam int unsigned GapW = $clog2(GAP_HALVES + 1);
    localparam logic [TogW-1:0] TogTerm = TogW'(2 * BURST_LEN - 1);
    localparam logic [GapW-1:0] GapTerm = GapW'(GAP_HALVES - 1);

    localparam logic [1:0] ModeOff   = 2'b00;
    localparam logic [1:0] ModeOn    = 2'b01;
    localparam logic [1:0] ModeBlink = 2'b10;
    localparam logic [1:0] ModeBurst = 2'b11;

    typedef enum logic {StPulse, StGap} burst_st_e;

    if (HALF_0 < 2 || HALF_1 < 2 || HALF_2 < 2 || HALF_3 < 2) begin : g_bad_half_min
        $error("led_blink_array: every HALF_x must be >= 2");
    end
    if (longint'(HALF_0) > (longint'(1) << CNT_W) || longint'(HALF_1) > (longint'(1) << CNT_W) ||
        longint'(HALF_2) > (longint'(1) << CNT_W) || longint'(HALF_3) > (longint'(1) << CNT_W))
    begin : g_bad_half_max
        $error("led_blink_array: every HALF_x must be <= 2**CNT_W");
    end
    if (BURST_LEN < 1 || GAP_HALVES < 1) begin : g_bad_burst
        $error("led_blink_array: BURST_LEN and GAP_HALVES must be >= 1");
    end

    function automatic logic [CNT_W-1:0] half_term(input logic [1:0] sel);
        logic [CNT_W-1:0] term;
        case (sel)
            2'b00:   term = CNT_W'(HALF_0 - 1);
            2'b01:   term = CNT_W'(HALF_1 - 1);
            2'b10:   term = CNT_W'(HALF_2 - 1);
            default: term = CNT_W'(HALF_3 - 1);
        endcase
        return term;
    endfunction

    // Low en_q marks the first enabled cycle after reset or enable low as a phase-0 entry.
    logic                en_q;
    logic [2*NUM_CH-1:0] mode_q;
    logic [2*NUM_CH-1:0] rate_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            en_q   <= 1'b0;
            mode_q <= '0;
            rate_q <= '0;
        end else begin
            en_q   <= enable_i;
            mode_q <= mode_i;
            rate_q <= rate_sel_i;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [1:0]       mode_c;
        logic [1:0]       rate_c;
        logic [CNT_W-1:0] term;
        logic             wrap;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             led_q, led_d;
        burst_st_e        st_q, st_d;
        logic [TogW-1:0]  tog_q, tog_d;
        logic [GapW-1:0]  gap_q, gap_d;

        assign mode_c = mode_i[2*g +: 2];
        assign rate_c = rate_sel_i[2*g +: 2];
        assign term   = half_term(rate_c);
        assign wrap   = (cnt_q == term);

        always_comb begin
            cnt_d = cnt_q;
            led_d = led_q;
            st_d  = st_q;
            tog_d = tog_q;
            gap_d = gap_q;
            if (!enable_i) begin
                cnt_d = '0;
                led_d = 1'b0;
                st_d  = StPulse;
                tog_d = '0;
                gap_d = '0;
            end else if (!en_q || sync_i || (mode_c != mode_q[2*g +: 2])) begin
                cnt_d = '0;
                led_d = (mode_c == ModeOn);
                st_d  = StPulse;
                tog_d = '0;
                gap_d = '0;
            end else if (rate_c != rate_q[2*g +: 2]) begin
                cnt_d = '0;
            end else begin
                unique case (mode_c)
                    ModeOff: begin
                        cnt_d = '0;
                        led_d = 1'b0;
                    end
                    ModeOn: begin
                        cnt_d = '0;
                        led_d = 1'b1;
                    end
                    ModeBlink: begin
                        if (wrap) begin
                            cnt_d = '0;
                            led_d = ~led_q;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    ModeBurst: begin
                        if (!wrap) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            cnt_d = '0;
                            if (st_q == StPulse) begin
                                if (tog_q == TogTerm) begin
                                    led_d = 1'b0;
                                    st_d  = StGap;
                                    tog_d = '0;
                                    gap_d = '0;
                                end else begin
                                    led_d = ~led_q;
                                    tog_d = tog_q + TogW'(1);
                                end
                            end else if (gap_q == GapTerm) begin
                                st_d  = StPulse;
                                gap_d = '0;
                            end else begin
                                gap_d = gap_q + GapW'(1);
                            end
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge clock_i or negedge reset_ni) begin
            if (!reset_ni) begin
                cnt_q <= '0;
                led_q <= 1'b0;
                st_q  <= StPulse;
                tog_q <= '0;
                gap_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                led_q <= led_d;
                st_q  <= st_d;
                tog_q <= tog_d;
                gap_q <= gap_d;
            end
        end

        assign led_o[g] = led_q;
    end

endmodule

// File: tb/tb_led_blink_array.sv
// Bench for led_blink_array: directed scenarios plus randomized input traffic,
// every cycle compared against a half-period-counting reference model.
module tb_led_blink_array;

    localparam int unsigned NumCh     = 4;
    localparam int unsigned BurstLen  = 3;
    localparam int unsigned GapHalves = 4;
    localparam int unsigned BurstHalves = 2 * BurstLen + GapHalves;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       sync;
    logic [7:0] mode;
    logic [7:0] rate_sel;
    logic [3:0] led;

    int unsigned half_tbl [4] = '{2, 3, 5, 8};

    int checks = 0;
    int errors = 0;

    always #10 clock = ~clock;

    led_blink_array #(
        .NUM_CH     (NumCh),
        .CNT_W      (4),
        .HALF_0     (2),
        .HALF_1     (3),
        .HALF_2     (5),
        .HALF_3     (8),
        .BURST_LEN  (BurstLen),
        .GAP_HALVES (GapHalves)
    ) u_dut (
        .clock_i    (clock),
        .reset_ni   (reset_n),
        .enable_i   (enable),
        .sync_i     (sync),
        .mode_i     (mode),
        .rate_sel_i (rate_sel),
        .led_o      (led)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: counts completed half-periods since phase 0 and the clocks inside the current half.
    int         hc [NumCh];
    int         pc [NumCh];
    logic [1:0] pm [NumCh];
    logic [1:0] pr [NumCh];
    logic       pen;
    logic [3:0] mled;

    task automatic model_reset();
        for (int c = 0; c < NumCh; c++) begin
            hc[c] = 0;
            pc[c] = 0;
            pm[c] = 2'b00;
            pr[c] = 2'b00;
        end
        pen  = 1'b0;
        mled = 4'b0;
    endtask

    task automatic model_step();
        logic [1:0] m;
        logic [1:0] r;
        int         h;
        int         pos;
        for (int c = 0; c < NumCh; c++) begin
            m = mode[2*c +: 2];
            r = rate_sel[2*c +: 2];
            h = int'(half_tbl[r]);
            if (!enable) begin
                hc[c] = 0;
                pc[c] = 0;
                mled[c] = 1'b0;
            end else if (!pen || sync || m != pm[c]) begin
                hc[c] = 0;
                pc[c] = 0;
                mled[c] = (m == 2'b01);
            end else if (r != pr[c]) begin
                pc[c] = 0;
            end else if (m == 2'b00) begin
                mled[c] = 1'b0;
            end else if (m == 2'b01) begin
                mled[c] = 1'b1;
            end else begin
                pc[c]++;
                if (pc[c] == h) begin
                    pc[c] = 0;
                    hc[c]++;
                end
                if (m == 2'b10) begin
                    mled[c] = (hc[c] % 2) == 1;
                end else begin
                    pos = hc[c] % int'(BurstHalves);
                    mled[c] = (pos < int'(2 * BurstLen)) && (pos % 2 == 1);
                end
            end
            pm[c] = m;
            pr[c] = r;
        end
        pen = enable;
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        check_val("led_model", 32'(led), 32'(mled));
    endtask

    logic [3:0] hist [40];
    int         first;
    int         second;
    logic       exp_bit;
    int         pos20;

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b1;
        sync     = 1'b0;
        mode     = 8'hAA;
        rate_sel = 8'b11_10_01_00;
        model_reset();

        // Held in reset with blink selected: LEDs stay dark.
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check_val("reset_led", 32'(led), 32'h0);
        end
        @(negedge clock);
        reset_n = 1'b1;

        // Blink timing per rate after release.
        for (int i = 0; i < 40; i++) begin
            step();
            hist[i] = led;
        end
        for (int c = 0; c < NumCh; c++) begin
            first  = -1;
            second = -1;
            for (int i = 0; i < 40; i++) begin
                if (hist[i][c] && (i == 0 || !hist[i-1][c])) begin
                    if (first < 0) first = i;
                    else if (second < 0) second = i;
                end
            end
            check_val($sformatf("first_rise_ch%0d", c), 32'(first), 32'(half_tbl[c]));
            check_val($sformatf("period_ch%0d", c), 32'(second - first), 32'(2 * half_tbl[c]));
        end

        // Burst on ch0 with H=2, others off.
        mode     = 8'b00_00_00_11;
        rate_sel = 8'h00;
        for (int i = 0; i < 60; i++) begin
            step();
            pos20   = i % 20;
            exp_bit = (pos20 >= 2 && pos20 < 4) || (pos20 >= 6 && pos20 < 8) ||
                      (pos20 >= 10 && pos20 < 12);
            check_val("burst_ch0", 32'(led[0]), 32'(exp_bit));
            check_val("burst_others_off", 32'(led[3:1]), 32'h0);
        end

        // Rate change on ch1 (H 3 -> 8) at counter==1: level held, toggle 8 clocks later.
        mode     = 8'b00_00_10_00;
        rate_sel = 8'b00_00_01_00;
        step();
        step();
        rate_sel = 8'b00_00_11_00;
        for (int e = 2; e <= 10; e++) begin
            step();
            check_val("rate_change_ch1", 32'(led[1]), 32'(e == 10));
        end

        // Free-running blink, then sync restarts everyone at phase 0.
        mode     = 8'hAA;
        rate_sel = 8'b00_11_10_01;
        repeat (37) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_val("sync_led", 32'(led), 32'h0);
        repeat (20) step();

        // Enable dropped mid-burst, then restored.
        mode = 8'hFF;
        repeat (13) step();
        enable = 1'b0;
        step();
        check_val("enable_off", 32'(led), 32'h0);
        step();
        enable = 1'b1;
        repeat (30) step();

        // Constant modes.
        mode = 8'h55;
        repeat (3) step();
        check_val("mode_on", 32'(led), 32'hF);
        mode = 8'h00;
        repeat (3) step();
        check_val("mode_off", 32'(led), 32'h0);

        // Asynchronous reset between edges, with ch0 on and the rest bursting.
        mode = 8'hFD;
        repeat (9) step();
        check_val("pre_reset_ch0", 32'(led[0]), 32'h1);
        #4;
        reset_n = 1'b0;
        #1;
        check_val("async_reset", 32'(led), 32'h0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step();
            sync = 1'b0;
            for (int c = 0; c < NumCh; c++) begin
                if ($urandom_range(0, 39) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 59) == 0) rate_sel[2*c +: 2] = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 49) == 0) sync = 1'b1;
            if (enable) begin
                if ($urandom_range(0, 79) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                enable = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
